// File: rtl/iterative_int_alu.sv
// Integer ALU: single-cycle arithmetic/logic/shift/count/compare ops plus an iterative
// restoring divider (one quotient bit per cycle). Valid/ready on both sides, tag returned.
module iterative_int_alu #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);

  localparam int unsigned SHAMT_BITS = $clog2(WIDTH);
  localparam int unsigned CNT_BITS   = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StDiv} state_e;

  state_e                 state_q, state_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       out_result_q, out_result_d;
  logic [TAG_WIDTH-1:0]   out_tag_q, out_tag_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       quo_q, quo_d;
  logic [WIDTH-1:0]       dvsr_q, dvsr_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic                   q_neg_q, q_neg_d;
  logic                   r_neg_q, r_neg_d;
  logic                   dz_q, dz_d;
  logic                   want_rem_q, want_rem_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;

  logic                   accept;
  logic [WIDTH-1:0]       alu_res;
  logic [SHAMT_BITS-1:0]  shamt;
  logic                   shamt_big;
  logic [CNT_BITS-1:0]    clz_cnt, ctz_cnt;
  logic                   is_div, div_signed, a_neg, b_neg;
  logic [WIDTH:0]         trial;
  logic                   step_ok;
  logic [WIDTH-1:0]       rem_step, quo_step, q_fin, r_fin, div_res;
  logic                   last_iter, stall;

  assign shamt     = in_b[SHAMT_BITS-1:0];
  assign shamt_big = |in_b[WIDTH-1:SHAMT_BITS];

  always_comb begin
    clz_cnt = CNT_BITS'(WIDTH);
    ctz_cnt = CNT_BITS'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (in_b[i]) clz_cnt = CNT_BITS'(int'(WIDTH) - 1 - i);
    end
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (in_b[i]) ctz_cnt = CNT_BITS'(i);
    end
  end

  always_comb begin
    alu_res = '0;
    case (in_op)
      4'd0:  alu_res = in_a + in_b;
      4'd1:  alu_res = in_a - in_b;
      4'd2:  alu_res = in_a & in_b;
      4'd3:  alu_res = in_a | in_b;
      4'd4:  alu_res = in_a ^ in_b;
      4'd5:  alu_res = shamt_big ? '0 : in_a << shamt;
      4'd6:  alu_res = shamt_big ? '0 : in_a >> shamt;
      4'd7:  alu_res = shamt_big ? {WIDTH{in_a[WIDTH-1]}} : $signed(in_a) >>> shamt;
      4'd8:  alu_res = {{(WIDTH-CNT_BITS){1'b0}}, clz_cnt};
      4'd9:  alu_res = {{(WIDTH-CNT_BITS){1'b0}}, ctz_cnt};
      4'd10: alu_res = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      4'd11: alu_res = {{(WIDTH-1){1'b0}}, in_a < in_b};
      default: alu_res = '0;
    endcase
  end

  // Divide ops are 12..15; bit0 clear = signed, bit1 set = remainder.
  assign is_div     = (in_op[3:2] == 2'b11);
  assign div_signed = ~in_op[0];
  assign a_neg      = div_signed & in_a[WIDTH-1];
  assign b_neg      = div_signed & in_b[WIDTH-1];

  // Partial remainder stays below the divisor, so WIDTH+1 bits cannot overflow.
  assign trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsr_q};
  assign step_ok  = ~trial[WIDTH];
  assign rem_step = step_ok ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign quo_step = {quo_q[WIDTH-2:0], step_ok};
  assign q_fin    = dz_q ? '1 : (q_neg_q ? -quo_step : quo_step);
  assign r_fin    = r_neg_q ? -rem_step : rem_step;
  assign div_res  = want_rem_q ? r_fin : q_fin;

  assign last_iter = (cnt_q == CNT_BITS'(WIDTH - 1));
  assign stall     = last_iter & out_valid_q & ~out_ready;

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvsr_d       = dvsr_q;
    cnt_d        = cnt_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    dz_d         = dz_q;
    want_rem_d   = want_rem_q;
    tag_d        = tag_q;
    in_ready     = (state_q == StIdle) & (~out_valid_q | out_ready);
    busy         = (state_q == StDiv);
    accept       = in_valid & in_ready;

    if (out_ready) out_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_div) begin
            state_d    = StDiv;
            rem_d      = '0;
            quo_d      = a_neg ? -in_a : in_a;
            dvsr_d     = b_neg ? -in_b : in_b;
            cnt_d      = '0;
            q_neg_d    = a_neg ^ b_neg;
            r_neg_d    = a_neg;
            dz_d       = (in_b == '0);
            want_rem_d = in_op[1];
            tag_d      = in_tag;
          end else begin
            out_valid_d  = 1'b1;
            out_result_d = alu_res;
            out_tag_d    = in_tag;
          end
        end
      end
      StDiv: begin
        if (!stall) begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          if (last_iter) begin
            state_d      = StIdle;
            cnt_d        = '0;
            out_valid_d  = 1'b1;
            out_result_d = div_res;
            out_tag_d    = tag_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvsr_q       <= '0;
      cnt_q        <= '0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      dz_q         <= 1'b0;
      want_rem_q   <= 1'b0;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dvsr_q       <= dvsr_d;
      cnt_q        <= cnt_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
      dz_q         <= dz_d;
      want_rem_q   <= want_rem_d;
      tag_q        <= tag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule
